// File: rtl/axi_sram_if.sv
// AXI3 read/write channel bundle between the bus bridge master and the SRAM responder.
interface axi_sram_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      output wid, wdata, wstrb, wlast, wvalid, bready,
      input  arready, rid, rdata, rresp, rlast, rvalid,
      input  awready, wready, bid, bresp, bvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      input  wid, wdata, wstrb, wlast, wvalid, bready,
      output arready, rid, rdata, rresp, rlast, rvalid,
      output awready, wready, bid, bresp, bvalid
   );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 word-wide SRAM responder with independent single-burst read and write engines.
// Optional AXI_SLAVE_RANDOM_STALL_EN adds LFSR-driven ready stalls for protocol stress.
//
// state  | meaning
// R_IDLE | read address channel open
// R_DATA | streaming read beats
// W_IDLE | write address channel open
// W_DATA | accepting write beats
// W_RESP | holding write response
module axi_sram_slave #(
   parameter int MEM_WORDS = 4096
) (
   input logic       clk,
   input logic       reset,
   axi_sram_if.slave bus
);
   localparam int AW = $clog2(MEM_WORDS);

   typedef enum logic {R_IDLE, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   logic [31:0] mem [MEM_WORDS];

   r_state_t r_state, r_state_nxt;
   w_state_t w_state, w_state_nxt;

   logic [3:0]    r_id, r_len, r_beat;
   logic [1:0]    r_burst;
   logic [AW-1:0] r_idx;
   logic          r_err;
   logic [3:0]    w_id, w_len, w_beat;
   logic [1:0]    w_burst;
   logic [AW-1:0] w_idx;
   logic          w_err, b_err;

   logic stall;
   logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
   logic r_last, w_end;
   logic unused_bits;

`ifdef AXI_SLAVE_RANDOM_STALL_EN
   logic [15:0] lfsr;
   always_ff @(posedge clk) begin
      if (reset) lfsr <= 16'hACE1;
      else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end
   assign stall = lfsr[0];
`else
   assign stall = 1'b0;
`endif

   function automatic logic cfg_err(input logic [2:0] size, input logic [1:0] burst,
                                    input logic [3:0] len);
      cfg_err = (size != 3'd2) || (burst == 2'b11) ||
                ((burst == 2'b10) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
   endfunction

   // WRAP keeps the bits above the (len+1)-word window and wraps the low bits.
   function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx, input logic [1:0] burst,
                                              input logic [3:0] len);
      logic [AW-1:0] mask;
      mask = AW'(len);
      case (burst)
         2'b00:   next_idx = idx;
         2'b10:   next_idx = (idx & ~mask) | ((idx + AW'(1)) & mask);
         default: next_idx = idx + AW'(1);
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= R_IDLE;
         w_state <= W_IDLE;
      end else begin
         r_state <= r_state_nxt;
         w_state <= w_state_nxt;
      end
   end

   always_comb begin
      r_state_nxt = r_state;
      ar_hs       = 1'b0;
      r_hs        = 1'b0;
      r_last      = (r_beat == r_len);
      case (r_state)
         R_IDLE: begin
            ar_hs = bus.arvalid & ~stall;
            if (ar_hs) r_state_nxt = R_DATA;
         end
         R_DATA: begin
            r_hs = bus.rready;
            if (r_hs && r_last) r_state_nxt = R_IDLE;
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      w_state_nxt = w_state;
      aw_hs       = 1'b0;
      w_hs        = 1'b0;
      b_hs        = 1'b0;
      w_end       = bus.wlast | (w_beat == w_len);
      case (w_state)
         W_IDLE: begin
            aw_hs = bus.awvalid & ~stall;
            if (aw_hs) w_state_nxt = W_DATA;
         end
         W_DATA: begin
            w_hs = bus.wvalid & ~stall;
            if (w_hs && w_end) w_state_nxt = W_RESP;
         end
         W_RESP: begin
            b_hs = bus.bready;
            if (b_hs) w_state_nxt = W_IDLE;
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_id    <= '0;
         r_len   <= '0;
         r_beat  <= '0;
         r_burst <= '0;
         r_idx   <= '0;
         r_err   <= 1'b0;
         w_id    <= '0;
         w_len   <= '0;
         w_beat  <= '0;
         w_burst <= '0;
         w_idx   <= '0;
         w_err   <= 1'b0;
         b_err   <= 1'b0;
      end else begin
         if (ar_hs) begin
            r_id    <= bus.arid;
            r_idx   <= bus.araddr[AW+1:2];
            r_len   <= bus.arlen;
            r_burst <= bus.arburst;
            r_err   <= cfg_err(bus.arsize, bus.arburst, bus.arlen);
            r_beat  <= '0;
         end else if (r_hs) begin
            r_idx  <= next_idx(r_idx, r_burst, r_len);
            r_beat <= r_beat + 4'd1;
         end
         if (aw_hs) begin
            w_id    <= bus.awid;
            w_idx   <= bus.awaddr[AW+1:2];
            w_len   <= bus.awlen;
            w_burst <= bus.awburst;
            w_err   <= cfg_err(bus.awsize, bus.awburst, bus.awlen);
            w_beat  <= '0;
         end else if (w_hs) begin
            w_idx  <= next_idx(w_idx, w_burst, w_len);
            w_beat <= w_beat + 4'd1;
            // A wlast that disagrees with the beat count ends the burst with SLVERR.
            if (w_end) b_err <= w_err | (bus.wlast ^ (w_beat == w_len));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_hs && !w_err)
         for (int b = 0; b < 4; b++)
            if (bus.wstrb[b]) mem[w_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
   end

   assign bus.arready = (r_state == R_IDLE) & ~stall;
   assign bus.rvalid  = (r_state == R_DATA);
   assign bus.rdata   = (bus.rvalid && !r_err) ? mem[r_idx] : '0;
   assign bus.rresp   = (bus.rvalid && r_err) ? 2'b10 : 2'b00;
   assign bus.rlast   = bus.rvalid & r_last;
   assign bus.rid     = r_id;
   assign bus.awready = (w_state == W_IDLE) & ~stall;
   assign bus.wready  = (w_state == W_DATA) & ~stall;
   assign bus.bvalid  = (w_state == W_RESP);
   assign bus.bid     = w_id;
   assign bus.bresp   = {b_err, 1'b0};

   assign unused_bits = ^{bus.wid, bus.araddr[31:AW+2], bus.araddr[1:0],
                          bus.awaddr[31:AW+2], bus.awaddr[1:0]};
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave; with AXI_SLAVE_RANDOM_STALL_EN it runs a randomized model check.
module tb_axi_sram_slave;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   axi_sram_if bus ();
   axi_sram_slave #(.MEM_WORDS(4096)) dut (.clk(clk), .reset(reset), .bus(bus));

   int errors = 0;
   int checks = 0;

   logic [31:0] wd [16];
   logic [3:0]  ws [16];
   logic [31:0] rd [16];
   logic [1:0]  rr [16];
   logic        rl [16];
   logic [3:0]  rids [16];
   int          rbeats;
   logic [1:0]  b_resp;
   logic [3:0]  b_id;
   logic        lat_wready, lat_bvalid, lat_awready, lat_rvalid, lat_arready;

   logic        prev_rv = 1'b0, prev_bv = 1'b0;
   logic [31:0] prev_rdata = '0;
   logic [1:0]  prev_rresp = '0, prev_bresp = '0;

   // Valid/payload must hold until the handshake.
   always @(negedge clk) begin
      if (!reset) begin
         if (prev_rv) begin
            checks++;
            if (bus.rvalid !== 1'b1 || bus.rdata !== prev_rdata || bus.rresp !== prev_rresp) begin
               errors++;
               $display("FAIL r_hold: rvalid=%b rdata=%h required rvalid=1 rdata=%h", bus.rvalid, bus.rdata, prev_rdata);
            end
         end
         if (prev_bv) begin
            checks++;
            if (bus.bvalid !== 1'b1 || bus.bresp !== prev_bresp) begin
               errors++;
               $display("FAIL b_hold: bvalid=%b bresp=%b required bvalid=1 bresp=%b", bus.bvalid, bus.bresp, prev_bresp);
            end
         end
      end
      prev_rv    = !reset && bus.rvalid && !bus.rready;
      prev_bv    = !reset && bus.bvalid && !bus.bready;
      prev_rdata = bus.rdata;
      prev_rresp = bus.rresp;
      prev_bresp = bus.bresp;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_flag(input string name, ref logic flag);
      int to = 0;
      while (flag !== 1'b1 && to < 200) begin
         tick();
         to++;
      end
      checks++;
      if (to >= 200) begin
         errors++;
         $display("FAIL %s_timeout: waited %0d cycles, required fewer than 200", name, to);
      end
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input int last_at);
      int n;
      bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awburst = burst; bus.awsize = size;
      bus.awvalid = 1'b1;
      wait_flag("awready", bus.awready);
      tick();
      bus.awvalid = 1'b0;
      lat_wready = bus.wready;
      n = (last_at < int'(len)) ? last_at : int'(len);
      for (int i = 0; i <= n; i++) begin
         bus.wvalid = 1'b1; bus.wdata = wd[i]; bus.wstrb = ws[i]; bus.wlast = (i == last_at);
         bus.wid = id;
         wait_flag("wready", bus.wready);
         tick();
      end
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
      lat_bvalid = bus.bvalid;
      bus.bready = 1'b1;
      wait_flag("bvalid", bus.bvalid);
      b_resp = bus.bresp; b_id = bus.bid;
      tick();
      bus.bready = 1'b0;
      lat_awready = bus.awready;
   endtask

   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input logic [2:0] size);
      logic last;
      bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arburst = burst; bus.arsize = size;
      bus.arvalid = 1'b1;
      wait_flag("arready", bus.arready);
      tick();
      bus.arvalid = 1'b0;
      lat_rvalid = bus.rvalid;
      bus.rready = 1'b1;
      rbeats = 0;
      last = 1'b0;
      while (rbeats < 16 && !last) begin
         wait_flag("rvalid", bus.rvalid);
         rd[rbeats] = bus.rdata; rr[rbeats] = bus.rresp; rl[rbeats] = bus.rlast; rids[rbeats] = bus.rid;
         last = bus.rlast;
         tick();
         rbeats++;
      end
      bus.rready = 1'b0;
      lat_arready = bus.arready;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      checks += 11;
      if (bus.arready !== 1'b1) begin errors++; $display("FAIL rst_arready: got %b required 1", bus.arready); end
      if (bus.awready !== 1'b1) begin errors++; $display("FAIL rst_awready: got %b required 1", bus.awready); end
      if (bus.wready !== 1'b0) begin errors++; $display("FAIL rst_wready: got %b required 0", bus.wready); end
      if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b required 0", bus.rvalid); end
      if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid: got %b required 0", bus.bvalid); end
      if (bus.rid !== 4'h0) begin errors++; $display("FAIL rst_rid: got %h required 0", bus.rid); end
      if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h required 0", bus.rdata); end
      if (bus.rresp !== 2'b00) begin errors++; $display("FAIL rst_rresp: got %b required 00", bus.rresp); end
      if (bus.rlast !== 1'b0) begin errors++; $display("FAIL rst_rlast: got %b required 0", bus.rlast); end
      if (bus.bid !== 4'h0) begin errors++; $display("FAIL rst_bid: got %h required 0", bus.bid); end
      if (bus.bresp !== 2'b00) begin errors++; $display("FAIL rst_bresp: got %b required 00", bus.bresp); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_incr();
      for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
      do_write(4'd5, 32'h100, 4'd3, 2'b01, 3'd2, 3);
      checks += 5;
      if (b_resp !== 2'b00) begin errors++; $display("FAIL incr_bresp: got %b required 00", b_resp); end
      if (b_id !== 4'd5) begin errors++; $display("FAIL incr_bid: got %h required 5", b_id); end
      if (lat_wready !== 1'b1) begin errors++; $display("FAIL lat_wready: got %b required 1", lat_wready); end
      if (lat_bvalid !== 1'b1) begin errors++; $display("FAIL lat_bvalid: got %b required 1", lat_bvalid); end
      if (lat_awready !== 1'b1) begin errors++; $display("FAIL lat_awready: got %b required 1", lat_awready); end
      do_read(4'd9, 32'h100, 4'd3, 2'b01, 3'd2);
      checks += 3;
      if (rbeats !== 4) begin errors++; $display("FAIL incr_beats: got %0d required 4", rbeats); end
      if (lat_rvalid !== 1'b1) begin errors++; $display("FAIL lat_rvalid: got %b required 1", lat_rvalid); end
      if (lat_arready !== 1'b1) begin errors++; $display("FAIL lat_arready: got %b required 1", lat_arready); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rd[i] !== 32'(i + 1) || rr[i] !== 2'b00 || rl[i] !== (i == 3) || rids[i] !== 4'd9) begin
            errors++;
            $display("FAIL incr_beat%0d: data=%h resp=%b last=%b id=%h required data=%h resp=00 last=%b id=9",
                     i, rd[i], rr[i], rl[i], rids[i], 32'(i + 1), (i == 3));
         end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_incr [4];
      logic [31:0] exp_wrap [4];
      wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC; wd[3] = 32'hD;
      for (int i = 0; i < 4; i++) ws[i] = 4'hF;
      do_write(4'd3, 32'h10C, 4'd3, 2'b10, 3'd2, 3);
      checks++;
      if (b_resp !== 2'b00) begin errors++; $display("FAIL wrap_bresp: got %b required 00", b_resp); end
      // 0x10C,0x100,0x104,0x108 received A,B,C,D
      exp_incr[0] = 32'hB; exp_incr[1] = 32'hC; exp_incr[2] = 32'hD; exp_incr[3] = 32'hA;
      exp_wrap[0] = 32'hD; exp_wrap[1] = 32'hA; exp_wrap[2] = 32'hB; exp_wrap[3] = 32'hC;
      do_read(4'd1, 32'h100, 4'd3, 2'b01, 3'd2);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rd[i] !== exp_incr[i]) begin errors++; $display("FAIL wrap_incr_rd%0d: got %h required %h", i, rd[i], exp_incr[i]); end
      end
      do_read(4'd2, 32'h108, 4'd3, 2'b10, 3'd2);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rd[i] !== exp_wrap[i] || rr[i] !== 2'b00) begin
            errors++; $display("FAIL wrap_rd%0d: got %h resp %b required %h resp 00", i, rd[i], rr[i], exp_wrap[i]);
         end
      end
   endtask

   task automatic test_strobe();
      wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
      do_write(4'd0, 32'h20, 4'd0, 2'b01, 3'd2, 0);
      wd[0] = 32'h1122_3344; ws[0] = 4'b0101;
      do_write(4'd0, 32'h20, 4'd0, 2'b01, 3'd2, 0);
      do_read(4'd0, 32'h20, 4'd0, 2'b01, 3'd2);
      checks++;
      if (rd[0] !== 32'hFF22_FF44) begin errors++; $display("FAIL strobe: got %h required FF22FF44", rd[0]); end
   endtask

   task automatic test_errors();
      do_read(4'd6, 32'h100, 4'd1, 2'b01, 3'd1);
      checks += 3;
      if (rbeats !== 2) begin errors++; $display("FAIL rsize_beats: got %0d required 2", rbeats); end
      if (rd[0] !== 32'h0 || rr[0] !== 2'b10 || rl[0] !== 1'b0) begin
         errors++; $display("FAIL rsize_beat0: data=%h resp=%b last=%b required 0/10/0", rd[0], rr[0], rl[0]);
      end
      if (rd[1] !== 32'h0 || rr[1] !== 2'b10 || rl[1] !== 1'b1) begin
         errors++; $display("FAIL rsize_beat1: data=%h resp=%b last=%b required 0/10/1", rd[1], rr[1], rl[1]);
      end
      do_read(4'd6, 32'h100, 4'd2, 2'b10, 3'd2);
      checks++;
      if (rbeats !== 3 || rr[2] !== 2'b10 || rl[2] !== 1'b1) begin
         errors++; $display("FAIL rwrap_len: beats=%0d resp=%b last=%b required 3/10/1", rbeats, rr[2], rl[2]);
      end
      wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
      do_write(4'd7, 32'h20, 4'd0, 2'b11, 3'd2, 0);
      checks++;
      if (b_resp !== 2'b10 || b_id !== 4'd7) begin errors++; $display("FAIL wburst11: bresp=%b bid=%h required 10/7", b_resp, b_id); end
      wd[1] = 32'hDEAD_BEEF; ws[1] = 4'hF;
      do_write(4'd7, 32'h20, 4'd2, 2'b10, 3'd2, 2);
      checks++;
      if (b_resp !== 2'b10) begin errors++; $display("FAIL wwrap_len: bresp=%b required 10", b_resp); end
      do_read(4'd0, 32'h20, 4'd0, 2'b01, 3'd2);
      checks++;
      if (rd[0] !== 32'hFF22_FF44) begin errors++; $display("FAIL werr_nowrite: got %h required FF22FF44", rd[0]); end
      for (int i = 0; i < 4; i++) begin wd[i] = 32'h60 + 32'(i); ws[i] = 4'hF; end
      do_write(4'd1, 32'h200, 4'd3, 2'b01, 3'd2, 3);
      wd[0] = 32'h51; wd[1] = 32'h52;
      do_write(4'd1, 32'h200, 4'd3, 2'b01, 3'd2, 1);
      checks++;
      if (b_resp !== 2'b10) begin errors++; $display("FAIL early_wlast: bresp=%b required 10", b_resp); end
      do_read(4'd1, 32'h200, 4'd3, 2'b01, 3'd2);
      checks++;
      if (rd[0] !== 32'h51 || rd[1] !== 32'h52 || rd[2] !== 32'h62 || rd[3] !== 32'h63) begin
         errors++; $display("FAIL early_data: got %h %h %h %h required 51 52 62 63", rd[0], rd[1], rd[2], rd[3]);
      end
      wd[0] = 32'h71; wd[1] = 32'h72;
      do_write(4'd2, 32'h300, 4'd1, 2'b01, 3'd2, 99);
      checks++;
      if (b_resp !== 2'b10) begin errors++; $display("FAIL missing_wlast: bresp=%b required 10", b_resp); end
      do_read(4'd2, 32'h300, 4'd1, 2'b01, 3'd2);
      checks++;
      if (rd[0] !== 32'h71 || rd[1] !== 32'h72) begin errors++; $display("FAIL missing_data: got %h %h required 71 72", rd[0], rd[1]); end
   endtask

   task automatic test_fixed_alias();
      wd[0] = 32'h7; wd[1] = 32'h8; wd[2] = 32'h9;
      for (int i = 0; i < 3; i++) ws[i] = 4'hF;
      do_write(4'd4, 32'h400, 4'd2, 2'b00, 3'd2, 2);
      do_read(4'd4, 32'h400, 4'd1, 2'b00, 3'd2);
      checks++;
      if (rd[0] !== 32'h9 || rd[1] !== 32'h9) begin errors++; $display("FAIL fixed: got %h %h required 9 9", rd[0], rd[1]); end
      wd[0] = 32'h1234_5678; ws[0] = 4'hF;
      do_write(4'd4, 32'h0000_4040, 4'd0, 2'b01, 3'd2, 0);
      do_read(4'd4, 32'h43, 4'd0, 2'b01, 3'd2);
      checks++;
      if (rd[0] !== 32'h1234_5678) begin errors++; $display("FAIL alias: got %h required 12345678", rd[0]); end
   endtask

   task automatic test_rready_stall();
      bus.arid = 4'd8; bus.araddr = 32'h100; bus.arlen = 4'd3; bus.arburst = 2'b01; bus.arsize = 3'd2;
      bus.arvalid = 1'b1;
      tick();
      bus.arvalid = 1'b0;
      bus.rready = 1'b1;
      checks++;
      if (bus.rdata !== 32'hB) begin errors++; $display("FAIL stall_b0: got %h required B", bus.rdata); end
      tick();
      bus.rready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hC) begin
            errors++; $display("FAIL stall_hold%0d: rvalid=%b rdata=%h required 1/C", k, bus.rvalid, bus.rdata);
         end
         tick();
      end
      bus.rready = 1'b1;
      tick();
      checks++;
      if (bus.rdata !== 32'hD || bus.rlast !== 1'b0) begin errors++; $display("FAIL stall_b2: got %h last %b required D/0", bus.rdata, bus.rlast); end
      tick();
      checks++;
      if (bus.rdata !== 32'hA || bus.rlast !== 1'b1) begin errors++; $display("FAIL stall_b3: got %h last %b required A/1", bus.rdata, bus.rlast); end
      tick();
      bus.rready = 1'b0;
      checks++;
      if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
         errors++; $display("FAIL stall_end: rvalid=%b arready=%b required 0/1", bus.rvalid, bus.arready);
      end
   endtask

   task automatic test_concurrent();
      wd[0] = 32'h0BAD_0001; ws[0] = 4'hF;
      do_write(4'd0, 32'h500, 4'd0, 2'b01, 3'd2, 0);
      bus.awid = 4'd3; bus.awaddr = 32'h500; bus.awlen = 4'd0; bus.awburst = 2'b01; bus.awsize = 3'd2;
      bus.arid = 4'd4; bus.araddr = 32'h500; bus.arlen = 4'd0; bus.arburst = 2'b01; bus.arsize = 3'd2;
      bus.awvalid = 1'b1; bus.arvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0; bus.arvalid = 1'b0;
      bus.wvalid = 1'b1; bus.wdata = 32'h600D_0002; bus.wstrb = 4'hF; bus.wlast = 1'b1;
      bus.rready = 1'b1;
      #1;
      checks++;
      if (bus.rvalid !== 1'b1 || bus.wready !== 1'b1 || bus.rdata !== 32'h0BAD_0001) begin
         errors++; $display("FAIL same_word_old: rvalid=%b wready=%b rdata=%h required 1/1/0BAD0001", bus.rvalid, bus.wready, bus.rdata);
      end
      tick();
      bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.rready = 1'b0;
      bus.bready = 1'b1;
      checks++;
      if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || bus.bid !== 4'd3 || bus.rvalid !== 1'b0) begin
         errors++; $display("FAIL concurrent_b: bvalid=%b bresp=%b bid=%h rvalid=%b required 1/00/3/0", bus.bvalid, bus.bresp, bus.bid, bus.rvalid);
      end
      tick();
      bus.bready = 1'b0;
      do_read(4'd0, 32'h500, 4'd0, 2'b01, 3'd2);
      checks++;
      if (rd[0] !== 32'h600D_0002) begin errors++; $display("FAIL same_word_new: got %h required 600D0002", rd[0]); end
   endtask

   task automatic test_reset_mid();
      wd[0] = 32'h11; wd[1] = 32'h22; ws[0] = 4'hF; ws[1] = 4'hF;
      do_write(4'd0, 32'h600, 4'd1, 2'b01, 3'd2, 1);
      bus.awid = 4'd9; bus.awaddr = 32'h600; bus.awlen = 4'd3; bus.awburst = 2'b01; bus.awsize = 3'd2;
      bus.awvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0;
      bus.wvalid = 1'b1; bus.wdata = 32'h5A5A_0001; bus.wstrb = 4'hF; bus.wlast = 1'b0;
      tick();
      bus.wdata = 32'h5A5A_0002;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.wvalid = 1'b0;
      checks++;
      if (bus.awready !== 1'b1 || bus.wready !== 1'b0) begin
         errors++; $display("FAIL rstmid_ready: awready=%b wready=%b required 1/0", bus.awready, bus.wready);
      end
      bus.bready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL rstmid_bvalid%0d: got %b required 0", k, bus.bvalid); end
         tick();
      end
      bus.bready = 1'b0;
      do_read(4'd0, 32'h600, 4'd1, 2'b01, 3'd2);
      checks++;
      if (rd[0] !== 32'h5A5A_0001 || rd[1] !== 32'h22) begin
         errors++; $display("FAIL rstmid_mem: got %h %h required 5A5A0001 00000022", rd[0], rd[1]);
      end
   endtask

   task automatic test_random();
      logic [31:0] model [64];
      logic [1:0]  burst;
      logic [3:0]  len, id;
      int          w, idx;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; model[k*16 + i] = wd[i]; end
         do_write(4'(k), 32'(k * 64), 4'd15, 2'b01, 3'd2, 15);
      end
      for (int it = 0; it < 1000; it++) begin
         burst = 2'($urandom_range(0, 2));
         case ($urandom_range(0, 3))
            0: len = 4'd1;
            1: len = 4'd3;
            2: len = 4'd7;
            default: len = 4'd15;
         endcase
         if (burst != 2'b10) len = 4'($urandom_range(0, 15));
         w = $urandom_range(0, 63);
         if (burst == 2'b01 && w > 63 - int'(len)) w = 63 - int'(len);
         id = 4'($urandom_range(0, 15));
         idx = w;
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i <= int'(len); i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
            do_write(id, 32'(w * 4) | 32'($urandom_range(0, 3) << 14), len, burst, 3'd2, int'(len));
            checks++;
            if (b_resp !== 2'b00 || b_id !== id) begin errors++; $display("FAIL rnd_b%0d: bresp=%b bid=%h required 00/%h", it, b_resp, b_id, id); end
            for (int i = 0; i <= int'(len); i++) begin
               for (int b = 0; b < 4; b++) if (ws[i][b]) model[idx][8*b +: 8] = wd[i][8*b +: 8];
               if (burst == 2'b01) idx = idx + 1;
               else if (burst == 2'b10) idx = (idx & ~int'(len)) | ((idx + 1) & int'(len));
            end
         end else begin
            do_read(id, 32'(w * 4), len, burst, 3'd2);
            checks++;
            if (rbeats !== int'(len) + 1) begin errors++; $display("FAIL rnd_beats%0d: got %0d required %0d", it, rbeats, int'(len) + 1); end
            for (int i = 0; i < rbeats; i++) begin
               checks++;
               if (rd[i] !== model[idx] || rr[i] !== 2'b00 || rids[i] !== id) begin
                  errors++; $display("FAIL rnd_r%0d_%0d: data=%h resp=%b id=%h required %h/00/%h", it, i, rd[i], rr[i], rids[i], model[idx], id);
               end
               if (burst == 2'b01) idx = idx + 1;
               else if (burst == 2'b10) idx = (idx & ~int'(len)) | ((idx + 1) & int'(len));
            end
         end
      end
   endtask

   initial begin
      bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd2; bus.arburst = 2'b01;
      bus.arvalid = 1'b0; bus.rready = 1'b0;
      bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd2; bus.awburst = 2'b01;
      bus.awvalid = 1'b0; bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
      bus.wvalid = 1'b0; bus.bready = 1'b0;
`ifdef AXI_SLAVE_RANDOM_STALL_EN
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick();
      test_random();
`else
      test_reset();
      test_incr();
      test_wrap();
      test_strobe();
      test_errors();
      test_fixed_alias();
      test_rready_stall();
      test_concurrent();
      test_reset_mid();
`endif
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
